// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_rx
// Description : WS2812 single-wire NRZ stream receiver. Synchronizes din,
//               measures high-pulse widths to decode bits MSB-first, assembles
//               24-bit GRB pixels and flags frame boundaries and protocol
//               violations.
// Ports       : sys_clk    - system clock, rising edge
//               sys_rst    - asynchronous active-high reset
//               din        - WS2812 data line (asynchronous)
//               pix_valid  - one-cycle strobe, pix_data/pix_index valid
//               pix_data   - decoded pixel, first-received bit in [23]
//               pix_index  - 0-based pixel position in the frame
//               frame_done - one-cycle strobe at end of a clean frame
//               err        - one-cycle strobe on a protocol violation
//               frame_cnt  - completed-frame count
// Options     : define WS2812_RX_FRAME_CNT_EN to enable the frame counter;
//               otherwise frame_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_rx #(
  parameter int T_MIN    = 8,
  parameter int T_THRESH = 30,
  parameter int T_MAX_H  = 100,
  parameter int T_RESET  = 2500,
  parameter int PIX_MAX  = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        din,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [6:0]  pix_index,
  output logic        frame_done,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // The "-1" forms compare against the count of cycles already seen, so the
  // decision is taken in the cycle that completes the T_xxx-th cycle.
  localparam logic [11:0] c_tmin      = 12'(T_MIN);
  localparam logic [11:0] c_tthresh   = 12'(T_THRESH);
  localparam logic [11:0] c_tmaxh_m1  = 12'(T_MAX_H - 1);
  localparam logic [11:0] c_treset_m1 = 12'(T_RESET - 1);
  localparam logic [11:0] c_pix_max   = 12'(PIX_MAX);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic        r_din_meta, r_din_s, r_din_d;
  logic        w_rise, w_fall;
  logic [2:0]  r_state, w_state_next;
  logic [11:0] r_hcnt, r_lcnt, r_pix_cnt;
  logic [4:0]  r_bit_cnt;
  logic [22:0] r_shift;
  logic        r_pix_valid, r_frame_done, r_err;
  logic [23:0] r_pix_data;
  logic [6:0]  r_pix_index;
  logic        w_bit_done, w_bit_val, w_pix_done, w_pix_out;
  logic        w_frame_end, w_frame_done, w_enter_err, w_enter_idle, w_err;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_din_meta <= 1'b0;
      r_din_s    <= 1'b0;
      r_din_d    <= 1'b0;
    end else begin
      r_din_meta <= din;
      r_din_s    <= r_din_meta;
      r_din_d    <= r_din_s;
    end
  end

  assign w_rise = r_din_s & ~r_din_d;
  assign w_fall = ~r_din_s & r_din_d;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_SYNC;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC, S_ERR: begin
        if (!r_din_s && (r_lcnt >= c_treset_m1)) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_rise) w_state_next = S_HIGH;
      end
      S_HIGH: begin
        // r_hcnt equals the full pulse width in the falling-edge cycle
        if (w_fall)                      w_state_next = (r_hcnt < c_tmin) ? S_ERR : S_LOW;
        else if (r_hcnt >= c_tmaxh_m1)   w_state_next = S_ERR;
      end
      S_LOW: begin
        if (w_rise)                      w_state_next = S_HIGH;
        else if (r_lcnt >= c_treset_m1)  w_state_next = S_IDLE;
      end
      default: w_state_next = S_SYNC;
    endcase
  end

  // Output / event decode
  always_comb begin
    w_bit_done   = (r_state == S_HIGH) && w_fall && (r_hcnt >= c_tmin);
    w_bit_val    = (r_hcnt >= c_tthresh);
    w_pix_done   = w_bit_done && (r_bit_cnt == 5'd23);
    w_pix_out    = w_pix_done && (r_pix_cnt < c_pix_max);
    w_frame_end  = (r_state == S_LOW) && (w_state_next == S_IDLE);
    w_frame_done = w_frame_end && (r_bit_cnt == 5'd0) && (r_pix_cnt != 12'd0);
    w_enter_err  = (w_state_next == S_ERR) && (r_state != S_ERR);
    w_enter_idle = (w_state_next == S_IDLE) && (r_state != S_IDLE);
    // A frame gap in the middle of a pixel is also a violation
    w_err        = w_enter_err || (w_frame_end && (r_bit_cnt != 5'd0));
  end

  // Counters, shift register and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_hcnt       <= 12'd0;
      r_lcnt       <= 12'd0;
      r_pix_cnt    <= 12'd0;
      r_bit_cnt    <= 5'd0;
      r_shift      <= 23'd0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_pix_data   <= 24'd0;
      r_pix_index  <= 7'd0;
    end else begin
      r_pix_valid  <= w_pix_out;
      r_frame_done <= w_frame_done;
      r_err        <= w_err;

      case (r_state)
        S_SYNC, S_ERR: r_lcnt <= r_din_s ? 12'd0 : sat_inc(r_lcnt);
        S_IDLE: if (w_rise) r_hcnt <= 12'd1;
        S_HIGH: begin
          if (w_fall) r_lcnt <= 12'd1;
          else        r_hcnt <= sat_inc(r_hcnt);
        end
        S_LOW: begin
          if (w_rise) r_hcnt <= 12'd1;
          else        r_lcnt <= sat_inc(r_lcnt);
        end
        default: ;
      endcase

      // Low-run measurement restarts from zero once an error is flagged
      if (w_enter_err) r_lcnt <= 12'd0;

      if (w_bit_done) begin
        r_shift <= {r_shift[21:0], w_bit_val};
        if (w_pix_done) begin
          r_bit_cnt <= 5'd0;
          r_pix_cnt <= sat_inc(r_pix_cnt);
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end

      if (w_pix_out) begin
        r_pix_data  <= {r_shift, w_bit_val};
        r_pix_index <= r_pix_cnt[6:0];
      end

      // Every IDLE entry starts a fresh frame; any partial pixel is dropped
      if (w_enter_idle) begin
        r_bit_cnt <= 5'd0;
        r_pix_cnt <= 12'd0;
      end
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_index  = r_pix_index;
  assign frame_done = r_frame_done;
  assign err        = r_err;

`ifdef WS2812_RX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Updates on the same edge that raises frame_done, wrapping naturally
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)           r_frame_cnt <= 16'd0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
